// File: rtl/latch_write_driver.sv
// latch_write_driver: sequences one-word writes into a downstream level-sensitive latch.
// The driver takes one word per valid/ready handshake. It puts the word on lat_data,
// waits the setup window, pulses lat_en for the pulse window, and then holds lat_data
// for the hold window before it accepts the next word.
// All state updates happen on the FALLING edge of clk. rst is synchronous and active-high.
//
// Ports:
//   clk       clock, state updates on negedge
//   rst       synchronous active-high reset, sampled on negedge
//   in_valid  producer has a word
//   in_data   word to write (WIDTH bits)
//   in_ready  driver can accept a word; decoded from state (and rst) only
//   lat_data  registered data bus to the latch
//   lat_en    registered latch enable (latch transparent while high)
//   busy      registered, write sequence in progress
//   done      registered one-cycle pulse when a sequence completes
//
// Optional feature, macro LWD_READBACK_EN:
//   rb_data   latch output fed back for checking
//   rb_err    sticky compare-error flag, checked on the edge that leaves HOLD,
//             cleared only by rst

module latch_write_driver #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] lat_data,
    output logic             lat_en,
    output logic             busy,
    output logic             done
`ifdef LWD_READBACK_EN
    ,
    input  logic [WIDTH-1:0] rb_data,
    output logic             rb_err
`endif
);

    localparam int unsigned CNT_W = 4;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   lat_data_q, lat_data_d;
    logic               lat_en_q, lat_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef LWD_READBACK_EN
    logic               rb_err_q, rb_err_d;
`endif

    // State and registered outputs. The latch side samples on the falling edge.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lat_data_q <= '0;
            lat_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef LWD_READBACK_EN
            rb_err_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_data_q <= lat_data_d;
            lat_en_q   <= lat_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef LWD_READBACK_EN
            rb_err_q   <= rb_err_d;
`endif
        end
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_data_d = lat_data_q;
        lat_en_d   = lat_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef LWD_READBACK_EN
        rb_err_d   = rb_err_q;
`endif

        case (state_q)
            IDLE: begin
                lat_en_d = 1'b0;
                busy_d   = 1'b0;
                // in_ready is implied here: the reset path takes priority in the register.
                if (in_valid) begin
                    lat_data_d = in_data;
                    cnt_d      = SETUP_LOAD;
                    busy_d     = 1'b1;
                    state_d    = SETUP;
                end
            end

            SETUP: begin
                if (cnt_q == '0) begin
                    lat_en_d = 1'b1;
                    cnt_d    = PULSE_LOAD;
                    state_d  = PULSE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            PULSE: begin
                if (cnt_q == '0) begin
                    lat_en_d = 1'b0;
                    cnt_d    = HOLD_LOAD;
                    state_d  = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            HOLD: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
`ifdef LWD_READBACK_EN
                    // The latch has been closed for the whole hold window, so its output must match.
                    if (rb_data != lat_data_q) begin
                        rb_err_d = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready depends only on the state, so there is no combinational path from in_valid.
    assign in_ready = (state_q == IDLE) && !rst;

    assign lat_data = lat_data_q;
    assign lat_en   = lat_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef LWD_READBACK_EN
    assign rb_err   = rb_err_q;
`endif

endmodule

// File: tb/tb_latch_write_driver.sv
// Directed bench for latch_write_driver. The DUT updates on negedge clk.
// The bench drives inputs and samples outputs 1 time unit after each falling edge.
module tb_latch_write_driver;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b1;
    logic             rst;
    logic             in_valid, in_valid2;
    logic [WIDTH-1:0] in_data, in_data2;
    logic             in_ready, in_ready2;
    logic [WIDTH-1:0] lat_data, lat_data2;
    logic             lat_en, lat_en2;
    logic             busy, busy2;
    logic             done, done2;
`ifdef LWD_READBACK_EN
    logic [WIDTH-1:0] rb_data, rb_data2;
    logic             rb_err, rb_err2;
    assign rb_data  = lat_data ^ 32'h1;
    assign rb_data2 = lat_data2;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;
    int done_seen = 0;
    logic en_prev = 1'b0;

    always #5 clk = ~clk;

    latch_write_driver dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .lat_data(lat_data), .lat_en(lat_en), .busy(busy), .done(done)
`ifdef LWD_READBACK_EN
        , .rb_data(rb_data), .rb_err(rb_err)
`endif
    );

    latch_write_driver #(.WIDTH(WIDTH), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(4)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .lat_data(lat_data2), .lat_en(lat_en2), .busy(busy2), .done(done2)
`ifdef LWD_READBACK_EN
        , .rb_data(rb_data2), .rb_err(rb_err2)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one falling edge, then count rising lat_en and done pulses of dut.
    task automatic step();
        @(negedge clk);
        #1;
        if (lat_en && !en_prev) pulses++;
        en_prev = lat_en;
        if (done) done_seen++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_valid2 = 1'b0; in_data2 = '0;
        #1;
        step(); step();
        check("rst_lat_data", 64'(lat_data), 64'h0);
        check("rst_lat_en",   64'(lat_en),   64'h0);
        check("rst_done",     64'(done),     64'h0);
        check("rst_busy",     64'(busy),     64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h0);
`ifdef LWD_READBACK_EN
        check("rst_rb_err",   64'(rb_err),   64'h0);
`endif
        rst = 1'b0;
        #1;
        check("idle_in_ready", 64'(in_ready), 64'h1);

        // Single write with the default timing S=1, P=2, H=1.
        in_valid = 1'b1; in_data = 32'hA5A5_0001;
        step(); // edge N
        in_valid = 1'b0; in_data = 32'h0;
        check("w1_data_n",   64'(lat_data), 64'hA5A5_0001);
        check("w1_en_n",     64'(lat_en),   64'h0);
        check("w1_busy_n",   64'(busy),     64'h1);
        check("w1_ready_n",  64'(in_ready), 64'h0);
        step(); check("w1_en_n1", 64'(lat_en), 64'h1);
        step(); check("w1_en_n2", 64'(lat_en), 64'h1);
        step(); check("w1_en_n3", 64'(lat_en), 64'h0);
        check("w1_data_n3", 64'(lat_data), 64'hA5A5_0001);
        step();
        check("w1_done_n4",  64'(done),     64'h1);
        check("w1_ready_n4", 64'(in_ready), 64'h1);
        check("w1_busy_n4",  64'(busy),     64'h0);
`ifdef LWD_READBACK_EN
        check("rb_err_first", 64'(rb_err), 64'h1);
`endif
        step();
        check("w1_done_n5",  64'(done),     64'h0);
        check("w1_idle_data", 64'(lat_data), 64'hA5A5_0001);

        // Stall, then back-to-back: accept 0x1, toggle valid with 0xDEADBEEF while busy, and present 0x2 in the done cycle.
        pulses = 0;
        in_valid = 1'b1; in_data = 32'h1;
        step(); // accept edge N
        check("b2b_data_n", 64'(lat_data), 64'h1);
        for (int k = 1; k <= 4; k++) begin
            in_valid = k[0]; in_data = 32'hDEAD_BEEF;
            if (k == 4) begin in_valid = 1'b1; in_data = 32'h2; end
            step();
            check("stall_data", 64'(lat_data), 64'h1);
        end
        check("b2b_done_n4", 64'(done), 64'h1);
        check("stall_pulses", 64'(pulses), 64'd1);
        step(); // N+5: the edge that ends the done cycle accepts 0x2
        in_valid = 1'b0;
        check("b2b_accept_n5", 64'(lat_data), 64'h2);
        check("b2b_busy_n5",   64'(busy),     64'h1);
        step(); step(); step(); step();
        check("b2b_done2",   64'(done),     64'h1);
        check("b2b_data2",   64'(lat_data), 64'h2);
        check("b2b_pulses",  64'(pulses),   64'd2);
`ifdef LWD_READBACK_EN
        check("rb_err_sticky", 64'(rb_err), 64'h1);
`endif
        step();

        // Reset in the middle of PULSE.
        in_valid = 1'b1; in_data = 32'h33;
        step(); // N
        in_valid = 1'b0;
        step(); // N+1
        check("mid_en_n1", 64'(lat_en), 64'h1);
        rst = 1'b1;
        done_seen = 0;
        step(); // N+2 with rst=1
        check("mid_rst_en",    64'(lat_en),   64'h0);
        check("mid_rst_data",  64'(lat_data), 64'h0);
        check("mid_rst_ready", 64'(in_ready), 64'h0);
        check("mid_rst_busy",  64'(busy),     64'h0);
`ifdef LWD_READBACK_EN
        check("mid_rst_rb_err", 64'(rb_err), 64'h0);
`endif
        rst = 1'b0;
        step(); step(); step();
        check("mid_no_done", 64'(done_seen), 64'd0);
        check("mid_ready_after", 64'(in_ready), 64'h1);
        in_valid = 1'b1; in_data = 32'h44;
        step();
        in_valid = 1'b0;
        step(); step(); step(); step();
        check("post_rst_done", 64'(done),     64'h1);
        check("post_rst_data", 64'(lat_data), 64'h44);

        // Parameter sweep on dut2 with S=3, P=1, H=4.
        in_valid2 = 1'b1; in_data2 = 32'h0000_00FF;
        step(); // N
        in_valid2 = 1'b0;
        check("sw_data_n", 64'(lat_data2), 64'hFF);
        check("sw_ready_n", 64'(in_ready2), 64'h0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("sw_en_n%0d", k),   64'(lat_en2), (k == 3) ? 64'h1 : 64'h0);
            check($sformatf("sw_done_n%0d", k), 64'(done2),   (k == 8) ? 64'h1 : 64'h0);
        end
        check("sw_busy_end", 64'(busy2), 64'h0);
`ifdef LWD_READBACK_EN
        check("sw_rb_err", 64'(rb_err2), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
